// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, paddle FSM states and direction decode
package pong_pkg;
  localparam int SCREEN_H = 480;
  localparam int TOP_MARGIN = 25;
  localparam int PADDLE_H = 72;
  localparam int BALL_SIZE = 8;
  typedef enum logic [1:0] {IDLE, MOVE_SLOW, MOVE_FAST} pstate_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;
  function automatic dir_e decode_dir(input logic up, input logic dn);
    return (up && !dn) ? DIR_UP : (dn && !up) ? DIR_DOWN : DIR_NONE;
  endfunction
endpackage

// File: rtl/paddle_axis.sv
// paddle_axis: button synchronizer, speed-ramp FSM, hold counter and wall clamp for one paddle
module paddle_axis
  import pong_pkg::*;
#(
  parameter int Y_MAX = 383,
  parameter int SPEED_SLOW = 2,
  parameter int SPEED_FAST = 4,
  parameter int RAMP_TICKS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       freeze,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       ovr_en_i,
  input  dir_e       ovr_dir_i,
  output logic [9:0] y_o,
  output logic       moving_o
);
  localparam int HW = $clog2(RAMP_TICKS + 1);
  localparam logic [9:0] Y_RST = 10'(Y_MAX / 2);
  logic [1:0] up_sync_q, dn_sync_q;
  pstate_e state_q, state_d;
  dir_e last_q, last_d, dir;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [9:0] y_q, y_d, step, y_up, y_dn;
  logic [10:0] y_sum;
  logic moving_q, moving_d, same;
  // two-flop synchronizers; they keep running through freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      up_sync_q <= {up_sync_q[0], up_i};
      dn_sync_q <= {dn_sync_q[0], down_i};
    end
  end
  // next state: a tick either starts/continues motion or drops to IDLE; steps clamp to the field
  always_comb begin
    dir = ovr_en_i ? ovr_dir_i : decode_dir(up_sync_q[1], dn_sync_q[1]);
    same = (state_q != IDLE) && (dir == last_q);
    hold_inc = hold_q + 1'b1;
    step = (same && state_q == MOVE_FAST) ? 10'(SPEED_FAST) : 10'(SPEED_SLOW);
    y_up = (y_q < step) ? '0 : y_q - step;
    y_sum = {1'b0, y_q} + {1'b0, step};
    y_dn = (y_sum > 11'(Y_MAX)) ? 10'(Y_MAX) : y_sum[9:0];
    state_d = state_q;
    last_d = last_q;
    hold_d = hold_q;
    y_d = y_q;
    moving_d = moving_q;
    if (freeze) begin
      state_d = IDLE;
      hold_d = '0;
      moving_d = 1'b0;
    end else if (refresh_tick) begin
      last_d = dir;
      y_d = (dir == DIR_UP) ? y_up : (dir == DIR_DOWN) ? y_dn : y_q;
      moving_d = (y_d != y_q);
      if (dir == DIR_NONE) begin
        state_d = IDLE;
        hold_d = '0;
      end else if (!same) begin
        state_d = MOVE_SLOW;
        hold_d = '0;
      end else if (state_q == MOVE_SLOW) begin
        hold_d = hold_inc;
        state_d = (hold_inc == HW'(RAMP_TICKS)) ? MOVE_FAST : MOVE_SLOW;
      end
    end
  end
  // FSM, hold counter and position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= DIR_NONE;
      hold_q <= '0;
      y_q <= Y_RST;
      moving_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      hold_q <= hold_d;
      y_q <= y_d;
      moving_q <= moving_d;
    end
  end
  assign y_o = y_q;
  assign moving_o = moving_q;
endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: two independent paddles; AI_PADDLE2_EN adds a ball-tracking CPU for paddle 2
module paddle_ctrl #(
  parameter int PADDLE_H = pong_pkg::PADDLE_H,
  parameter int TOP_MARGIN = pong_pkg::TOP_MARGIN,
  parameter int SCREEN_H = pong_pkg::SCREEN_H,
  parameter int SPEED_SLOW = 2,
  parameter int SPEED_FAST = 4,
  parameter int RAMP_TICKS = 15,
  parameter int AI_DEADZONE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       freeze,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       ai_mode,
  input  logic [9:0] ball_y,
  input  logic [9:0] ball_dx,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic       p1_moving,
  output logic       p2_moving
);
  localparam int Y_MAX = SCREEN_H - TOP_MARGIN - PADDLE_H;
  pong_pkg::dir_e ai_dir;
  logic ai_en;
`ifdef AI_PADDLE2_EN
  logic [10:0] target, center;
  logic unused_dx;
  assign target = {1'b0, ball_y} + 11'(pong_pkg::BALL_SIZE / 2);
  assign center = {1'b0, paddle2_y} + 11'(TOP_MARGIN + PADDLE_H / 2);
  assign unused_dx = ^ball_dx[8:0];
  // track the ball only while it approaches, with a dead zone around the paddle centre
  always_comb begin
    ai_dir = ball_dx[9] ? pong_pkg::DIR_NONE :
             (target + 11'(AI_DEADZONE) < center) ? pong_pkg::DIR_UP :
             (target > center + 11'(AI_DEADZONE)) ? pong_pkg::DIR_DOWN : pong_pkg::DIR_NONE;
  end
  assign ai_en = ai_mode;
`else
  logic unused_ai;
  assign unused_ai = ^{ball_y, ball_dx, ai_mode, AI_DEADZONE[0]};
  assign ai_dir = pong_pkg::DIR_NONE;
  assign ai_en = 1'b0;
`endif
  paddle_axis #(
    .Y_MAX(Y_MAX), .SPEED_SLOW(SPEED_SLOW), .SPEED_FAST(SPEED_FAST), .RAMP_TICKS(RAMP_TICKS)
  ) u_p1 (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .freeze(freeze),
    .up_i(p1_up), .down_i(p1_down), .ovr_en_i(1'b0), .ovr_dir_i(pong_pkg::DIR_NONE),
    .y_o(paddle1_y), .moving_o(p1_moving)
  );
  paddle_axis #(
    .Y_MAX(Y_MAX), .SPEED_SLOW(SPEED_SLOW), .SPEED_FAST(SPEED_FAST), .RAMP_TICKS(RAMP_TICKS)
  ) u_p2 (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .freeze(freeze),
    .up_i(p2_up), .down_i(p2_down), .ovr_en_i(ai_en), .ovr_dir_i(ai_dir),
    .y_o(paddle2_y), .moving_o(p2_moving)
  );
endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Produces paddle1_y and paddle2_y, the paddle positions that the ball/collision logic consumes.
- Player buttons are synchronized, then each paddle is moved once per refresh_tick. Movement uses a slow-to-fast speed ramp, and positions are clamped to the play field below the score margin.
- Sits between the board button inputs and the ball/renderer. Optionally provides a CPU opponent for paddle 2 that tracks the ball.

Parameters:
- PADDLE_H, 72, paddle height in pixels.
- TOP_MARGIN, 25, height of the score/timer band in pixels.
- SCREEN_H, 480, visible height in pixels.
- SPEED_SLOW, 2, pixels per tick in MOVE_SLOW.
- SPEED_FAST, 4, pixels per tick in MOVE_FAST.
- RAMP_TICKS, 15, number of held ticks in MOVE_SLOW before switching to MOVE_FAST.
- AI_DEADZONE, 8, half-width in pixels of the CPU no-move window.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- refresh_tick  in  1  one-cycle frame strobe.
- freeze  in  1  holds both paddles (game over / pause).
- p1_up, p1_down  in  1 each  player-1 buttons, asynchronous.
- p2_up, p2_down  in  1 each  player-2 buttons, asynchronous.
- ai_mode  in  1  selects CPU control of paddle 2 (effective only with AI_PADDLE2_EN).
- ball_y  in  10  ball top-left y coordinate.
- ball_dx  in  10  ball x velocity, two's complement.
- paddle1_y, paddle2_y  out  10 each  paddle top, relative to TOP_MARGIN.
- p1_moving, p2_moving  out  1 each  high when the paddle moved on the last tick.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous, active-high, named reset. All state is on the clk posedge.
- Y_MAX = SCREEN_H - TOP_MARGIN - PADDLE_H, which is 383 with the defaults.
- Reset values:
  - paddle1_y = paddle2_y = Y_MAX/2 (191).
  - moving flags = 0.
  - Both FSMs in IDLE.
  - Hold counters = 0.
  - Synchronizer flops = 0.
- Synchronization: every button passes through a 2-flop synchronizer. The synchronized level is what gets sampled.
- Tick sampling: each paddle evaluates only in a cycle where refresh_tick=1. The new y is visible the following cycle. Button-to-motion worst case is 2 cycles of sync plus the wait for the next tick.
- Direction decode (per paddle):
  - up only → UP.
  - down only → DOWN.
  - both or neither → NONE.
- FSM states per paddle: IDLE, MOVE_SLOW, MOVE_FAST.
  - IDLE: if dir ≠ NONE, go to MOVE_SLOW, hold_cnt=0, and move SPEED_SLOW on this same tick.
  - MOVE_SLOW:
    - dir=NONE → IDLE.
    - dir reversed → stay in MOVE_SLOW, hold_cnt=0.
    - Otherwise hold_cnt++.
    - If hold_cnt reaches RAMP_TICKS → MOVE_FAST.
  - MOVE_FAST:
    - dir=NONE → IDLE.
    - dir reversed → MOVE_SLOW, hold_cnt=0.
- Clamping (step = SPEED_SLOW or SPEED_FAST):
  - UP: y_next = (y < step) ? 0 : y - step.
  - DOWN: y_next = (y + step > Y_MAX) ? Y_MAX : y + step.
  - Comparisons use 11-bit arithmetic, so there is no 10-bit wrap.
- pN_moving = 1 only when y_next ≠ y on that tick. Pressing against a wall leaves the FSM advancing but moving=0.
- freeze=1:
  - FSMs forced to IDLE, hold_cnt cleared.
  - y held, moving=0.
  - Synchronizers keep running.
- Reset mid-motion returns to the reset values on the next edge, regardless of refresh_tick.
- Both paddles are fully independent; simultaneous presses on both paddles are legal.

Optional Feature:
- Macro: AI_PADDLE2_EN.
- Defined and ai_mode=1: paddle 2 ignores p2_up/p2_down and derives its direction each tick:
  - target = ball_y + 4.
  - center = paddle2_y + TOP_MARGIN + PADDLE_H/2.
  - target < center - AI_DEADZONE → UP.
  - target > center + AI_DEADZONE → DOWN.
  - Otherwise NONE.
  - Direction is also NONE whenever ball_dx[9]=1 (ball moving away).
  - The same FSM, ramp and clamp rules apply.
- Defined with ai_mode=0, or macro undefined: ball_y, ball_dx and ai_mode are ignored and paddle 2 follows the buttons. Ports are present in both builds.

Decomposition:
- pong_pkg holds:
  - Shared geometry constants: SCREEN_H, TOP_MARGIN, PADDLE_H, BALL_SIZE=8.
  - The paddle FSM state enum.
  - The direction enum (NONE/UP/DOWN).
- Sub-module paddle_axis: synchronizer, FSM, hold counter and clamp for one paddle, with a direction-override input. Instantiated twice. The AI direction logic lives in paddle_ctrl.

Test Plan:
1. Reset, then 3 ticks with no buttons → paddle1_y = paddle2_y = 191, moving flags 0.
2. Hold p1_down for 20 ticks from 191:
   - Ticks 1–16 add 2 each, giving 223.
   - Ticks 17–20 add 4 each, giving 239.
   - p1_moving=1 throughout.
3. Hold p1_up from y=3:
   - First tick → 1.
   - Next tick → 0.
   - Further ticks → 0 with p1_moving=0.
   - Hold p2_down near the bottom → paddle2_y clamps at 383, never 385 or a wrapped value.
4. p1_up and p1_down both held → no motion.
   - Switch from 10 fast ticks of down to up → first up step is 2 (MOVE_SLOW).
5. freeze=1 while p2_down is held → paddle2_y constant, FSM IDLE.
   - Release freeze with down still held → next tick moves by 2.
6. AI_PADDLE2_EN build, ai_mode=1, paddle2_y=191, ball_dx=+2:
   - ball_y=100 → paddle 2 moves up 2 per tick.
   - ball_y=248 → no motion.
   - ball_dx = -2 (10'h3FE) → no motion.
   - p2 buttons ignored.
